alu_exec: RTL and testbench

Parametrised execute-stage unit for the MIPS core. It replaces the single registered ALU-control decode with a combined decoder and ALU, and adds shifts, xor/nor, unsigned compares, and an iterative multiply/divide engine with HI/LO registers. It sits between the ID/EX pipeline register and the EX/MEM register, and exposes a valid/ready handshake so the hazard unit can stall issue while a multiply or divide runs. Undefined operations are flagged rather than producing don't-care outputs.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_exec_muldiv_iter.sv | 107 ++++++++++
 rtl/alu_exec.sv | 162 ++++++++++++++++
 tb/tb_alu_exec.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU: aluOp codes, R-type funct values and FSM states.
package alu_pkg;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_SLT   = 2'b11;

  localparam logic [5:0] F_SLL   = 6'd0;
  localparam logic [5:0] F_SRL   = 6'd2;
  localparam logic [5:0] F_SRA   = 6'd3;
  localparam logic [5:0] F_SLLV  = 6'd4;
  localparam logic [5:0] F_SRLV  = 6'd6;
  localparam logic [5:0] F_SRAV  = 6'd7;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MULT  = 6'd24;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIV   = 6'd26;
  localparam logic [5:0] F_DIVU  = 6'd27;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_ADDU  = 6'd33;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_SUBU  = 6'd35;
  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_XOR   = 6'd38;
  localparam logic [5:0] F_NOR   = 6'd39;
  localparam logic [5:0] F_SLT   = 6'd42;
  localparam logic [5:0] F_SLTU  = 6'd43;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;

endpackage

// File: rtl/alu_exec_muldiv_iter.sv
// Iterative multiply (shift-add) / restoring divide on magnitudes, one bit per cycle.
// Loads on start, then WIDTH steps; done flags the final step and hi/lo carry the sign-corrected result.
module muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int SH_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [SH_W:0] LAST = (SH_W+1)'(WIDTH-1);
  localparam logic [SH_W:0] ONE  = (SH_W+1)'(1);

  logic               busy_q, busy_d, div_q, div_d, neg_q, neg_d, neg_rem_q, neg_rem_d;
  logic [SH_W:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_q, acc_d, low_q, low_d, m_q, m_d;
  logic [WIDTH-1:0]   mag_a, mag_b, step_acc, step_low, quo, rem;
  logic [WIDTH:0]     sum, shifted, diff;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    mag_a   = (signed_op && a[WIDTH-1]) ? -a : a;
    mag_b   = (signed_op && b[WIDTH-1]) ? -b : b;
    // acc holds the running partial product / remainder, low the multiplier / quotient bits
    sum     = {1'b0, acc_q} + (low_q[0] ? {1'b0, m_q} : '0);
    shifted = {acc_q, low_q[WIDTH-1]};
    diff    = shifted - {1'b0, m_q};
    if (div_q) begin
      if (diff[WIDTH]) begin
        step_acc = shifted[WIDTH-1:0];
        step_low = {low_q[WIDTH-2:0], 1'b0};
      end else begin
        step_acc = diff[WIDTH-1:0];
        step_low = {low_q[WIDTH-2:0], 1'b1};
      end
    end else begin
      step_acc = sum[WIDTH:1];
      step_low = {sum[0], low_q[WIDTH-1:1]};
    end

    prod = {step_acc, step_low};
    if (neg_q) prod = -prod;
    quo  = neg_q     ? -step_low : step_low;
    rem  = neg_rem_q ? -step_acc : step_acc;
    hi   = div_q ? rem : prod[2*WIDTH-1:WIDTH];
    lo   = div_q ? quo : prod[WIDTH-1:0];
    done = busy_q && (cnt_q == LAST);

    busy_d    = busy_q;
    div_d     = div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    low_d     = low_q;
    m_d       = m_q;
    if (start) begin
      busy_d    = 1'b1;
      div_d     = is_div;
      neg_d     = signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_rem_d = signed_op && a[WIDTH-1];
      cnt_d     = '0;
      acc_d     = '0;
      low_d     = mag_a;
      m_d       = mag_b;
    end else if (busy_q) begin
      acc_d = step_acc;
      low_d = step_low;
      cnt_d = cnt_q + ONE;
      if (cnt_q == LAST) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q    <= 1'b0;
      div_q     <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      low_q     <= '0;
      m_q       <= '0;
    end else begin
      busy_q    <= busy_d;
      div_q     <= div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      low_q     <= low_d;
      m_q       <= m_d;
    end
  end

endmodule

// File: rtl/alu_exec.sv
// MIPS execute stage: decode + single-cycle ALU (1-cycle latency) plus iterative mult/div (WIDTH+1 cycles).
// in_ready is low while mult/div runs; offered operations are ignored until it returns high.
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SH_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       aluOp,
  input  logic [5:0]       funct,
  input  logic [SH_W-1:0]  shamt,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d, zero_q, zero_d, illegal_q, illegal_d;
  logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] alu_res, eng_hi, eng_lo;
  logic             alu_ill, dec_mul, dec_div, dec_signed, accept, start, eng_done;

  assign in_ready  = (state_q == IDLE);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

  always_comb begin
    alu_res    = '0;
    alu_ill    = 1'b0;
    dec_mul    = 1'b0;
    dec_div    = 1'b0;
    dec_signed = 1'b0;
    case (aluOp)
      ALU_ADD: alu_res = a + b;
      ALU_SUB: alu_res = a - b;
      ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      default: begin
        case (funct)
          F_SLL:            alu_res = b << shamt;
          F_SRL:            alu_res = b >> shamt;
          F_SRA:            alu_res = WIDTH'($signed(b) >>> shamt);
          F_SLLV:           alu_res = b << a[SH_W-1:0];
          F_SRLV:           alu_res = b >> a[SH_W-1:0];
          F_SRAV:           alu_res = WIDTH'($signed(b) >>> a[SH_W-1:0]);
          F_MFHI:           alu_res = hi_q;
          F_MFLO:           alu_res = lo_q;
          F_MULT, F_MULTU: begin
            dec_mul    = 1'b1;
            dec_signed = (funct == F_MULT);
          end
          F_DIV, F_DIVU: begin
            dec_div    = 1'b1;
            dec_signed = (funct == F_DIV);
          end
          F_ADD, F_ADDU:    alu_res = a + b;
          F_SUB, F_SUBU:    alu_res = a - b;
          F_AND:            alu_res = a & b;
          F_OR:             alu_res = a | b;
          F_XOR:            alu_res = a ^ b;
          F_NOR:            alu_res = ~(a | b);
          F_SLT:            alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
          F_SLTU:           alu_res = {{(WIDTH-1){1'b0}}, a < b};
          default:          alu_ill = 1'b1;
        endcase
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = 1'b0;
    result_d    = result_q;
    illegal_d   = illegal_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    start       = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (dec_mul) begin
            start   = 1'b1;
            state_d = MUL;
          end else if (dec_div && (b != '0)) begin
            start   = 1'b1;
            state_d = DIV;
          end else if (dec_div) begin
            // divide by zero resolves immediately instead of running the engine
            hi_d        = a;
            lo_d        = '1;
            result_d    = '1;
            illegal_d   = 1'b0;
            out_valid_d = 1'b1;
          end else begin
            result_d    = alu_res;
            illegal_d   = alu_ill;
            out_valid_d = 1'b1;
          end
        end
      end
      MUL, DIV: begin
        if (eng_done) begin
          hi_d        = eng_hi;
          lo_d        = eng_lo;
          result_d    = eng_lo;
          illegal_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      illegal_q   <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  muldiv_iter #(.WIDTH(WIDTH), .SH_W(SH_W)) u_muldiv (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .signed_op (dec_signed),
    .is_div    (dec_div),
    .a         (a),
    .b         (b),
    .done      (eng_done),
    .hi        (eng_hi),
    .lo        (eng_lo)
  );

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: expectations queued at issue, checked by a negedge monitor on out_valid.
module tb_alu_exec;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  aluOp = 2'b00;
  logic [5:0]  funct = 6'd0;
  logic [4:0]  shamt = 5'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        out_valid;
  logic [31:0] result;
  logic        zero;
  logic        illegal;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  int n_pulse = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        ill;
    logic        chk_hl;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  alu_exec #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .aluOp(aluOp), .funct(funct), .shamt(shamt), .a(a), .b(b),
    .out_valid(out_valid), .result(result), .zero(zero), .illegal(illegal),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic exp_t ex(input logic [31:0] r, input logic il, input logic hl,
                              input logic [31:0] h, input logic [31:0] l);
    exp_t e;
    e.res = r; e.ill = il; e.chk_hl = hl; e.hi = h; e.lo = l;
    return e;
  endfunction

  always @(negedge clk) begin
    if (out_valid) begin
      n_pulse++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: got result %h, no completion expected", result);
      end else begin
        mon_e = sb.pop_front();
        chk("result", result, mon_e.res);
        chk("zero", 32'(zero), 32'(mon_e.res == 32'd0));
        chk("illegal", 32'(illegal), 32'(mon_e.ill));
        if (mon_e.chk_hl) begin
          chk("hi", hi, mon_e.hi);
          chk("lo", lo, mon_e.lo);
        end
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] sh,
                       input logic [31:0] aa, input logic [31:0] bb, input bit push, input exp_t e);
    int n;
    if (push) sb.push_back(e);
    aluOp = op; funct = fn; shamt = sh; a = aa; b = bb; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: in_ready got 0 required 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Counts cycles after acceptance until out_valid; optionally pokes in_valid while busy.
  task automatic wait_done(output int cyc, output int low, input bit inject);
    cyc = 0;
    low = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (!in_ready) low++;
      if (inject && cyc == 1) begin
        aluOp = ALU_RTYPE; funct = F_ADD; a = 32'd100; b = 32'd100; in_valid = 1'b1;
      end
      if (inject && cyc == 20) in_valid = 1'b0;
    end while (!out_valid && cyc < 100);
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL completion_timeout: out_valid got 0 required 1 after %0d cycles", cyc);
    end
  endtask

  initial begin
    int cyc, low, p0;
    exp_t none;
    none = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    p0 = n_pulse;
    issue(ALU_RTYPE, F_ADD, 5'd0, 32'd5, 32'd7, 1'b1, ex(32'd12, 1'b0, 1'b0, 0, 0));
    issue(ALU_RTYPE, F_SUB, 5'd0, 32'd7, 32'd7, 1'b1, ex(32'd0, 1'b0, 1'b0, 0, 0));
    @(negedge clk); #1;
    chk("back_to_back_pulses", 32'(n_pulse - p0), 32'd2);

    issue(ALU_RTYPE, F_SLT,  5'd0, 32'hFFFFFFFF, 32'd1, 1'b1, ex(32'd1, 1'b0, 1'b0, 0, 0));
    issue(ALU_RTYPE, F_SLTU, 5'd0, 32'hFFFFFFFF, 32'd1, 1'b1, ex(32'd0, 1'b0, 1'b0, 0, 0));
    issue(ALU_RTYPE, F_SRA,  5'd4, 32'd0, 32'h80000000, 1'b1, ex(32'hF8000000, 1'b0, 1'b0, 0, 0));
    issue(ALU_RTYPE, F_SRLV, 5'd0, 32'd36, 32'h000000F0, 1'b1, ex(32'h0000000F, 1'b0, 1'b0, 0, 0));
    issue(ALU_RTYPE, F_SLL,  5'd31, 32'd0, 32'd1, 1'b1, ex(32'h80000000, 1'b0, 1'b0, 0, 0));
    issue(ALU_RTYPE, F_SRL,  5'd31, 32'd0, 32'h80000000, 1'b1, ex(32'd1, 1'b0, 1'b0, 0, 0));
    issue(ALU_RTYPE, F_AND,  5'd0, 32'h000000F0, 32'h0000003C, 1'b1, ex(32'h00000030, 1'b0, 1'b0, 0, 0));
    issue(ALU_RTYPE, F_XOR,  5'd0, 32'hA5A5A5A5, 32'hFFFF0000, 1'b1, ex(32'h5A5AA5A5, 1'b0, 1'b0, 0, 0));
    issue(ALU_RTYPE, F_NOR,  5'd0, 32'd0, 32'd0, 1'b1, ex(32'hFFFFFFFF, 1'b0, 1'b0, 0, 0));
    issue(ALU_ADD, 6'd0, 5'd0, 32'hFFFFFFFF, 32'd1, 1'b1, ex(32'd0, 1'b0, 1'b0, 0, 0));
    issue(ALU_SUB, 6'd0, 5'd0, 32'd3, 32'd5, 1'b1, ex(32'hFFFFFFFE, 1'b0, 1'b0, 0, 0));
    issue(ALU_SLT, 6'd0, 5'd0, 32'hFFFFFFFF, 32'd1, 1'b1, ex(32'd1, 1'b0, 1'b0, 0, 0));

    issue(ALU_RTYPE, F_MULT, 5'd0, 32'hFFFFFFFD, 32'd5, 1'b1,
          ex(32'hFFFFFFF1, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1));
    wait_done(cyc, low, 1'b1);
    chk("mult_latency", 32'(cyc), 32'd33);
    chk("mult_busy_cycles", 32'(low), 32'd32);
    issue(ALU_RTYPE, F_MFHI, 5'd0, 32'd0, 32'd0, 1'b1,
          ex(32'hFFFFFFFF, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1));
    issue(ALU_RTYPE, F_MULTU, 5'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1,
          ex(32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFE, 32'h00000001));
    wait_done(cyc, low, 1'b0);

    issue(ALU_RTYPE, F_DIV, 5'd0, 32'hFFFFFFF9, 32'd2, 1'b1,
          ex(32'hFFFFFFFD, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD));
    wait_done(cyc, low, 1'b0);
    chk("div_latency", 32'(cyc), 32'd33);
    chk("div_busy_cycles", 32'(low), 32'd32);
    issue(ALU_RTYPE, F_DIVU, 5'd0, 32'h80000000, 32'd3, 1'b1,
          ex(32'h2AAAAAAA, 1'b0, 1'b1, 32'd2, 32'h2AAAAAAA));
    wait_done(cyc, low, 1'b0);
    issue(ALU_RTYPE, F_DIV, 5'd0, 32'h80000000, 32'hFFFFFFFF, 1'b1,
          ex(32'h80000000, 1'b0, 1'b1, 32'd0, 32'h80000000));
    wait_done(cyc, low, 1'b0);
    issue(ALU_RTYPE, F_DIV, 5'd0, 32'd9, 32'd0, 1'b1,
          ex(32'hFFFFFFFF, 1'b0, 1'b1, 32'd9, 32'hFFFFFFFF));
    wait_done(cyc, low, 1'b0);
    chk("div0_latency", 32'(cyc), 32'd1);

    issue(ALU_RTYPE, 6'd63, 5'd0, 32'd1, 32'd2, 1'b1,
          ex(32'd0, 1'b1, 1'b1, 32'd9, 32'hFFFFFFFF));
    wait_done(cyc, low, 1'b0);
    chk("illegal_latency", 32'(cyc), 32'd1);

    issue(ALU_RTYPE, F_MULT, 5'd0, 32'd1234, 32'd5678, 1'b0, none);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_zero", 32'(zero), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    issue(ALU_RTYPE, F_ADD, 5'd0, 32'd1, 32'd1, 1'b1, ex(32'd2, 1'b0, 1'b1, 32'd0, 32'd0));
    wait_done(cyc, low, 1'b0);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
